rf_sequencer: RTL and testbench
===============================

Name: rf_sequencer

Overview:
- Command-driven master for the 8x8 single-read-port / single-write-port register file.
- Accepts one register-level operation at a time over a valid/ready handshake: load-immediate, move, add or subtract.
- Sequences the register file read and write ports over several cycles and reports the written result and flags.
- Sits between the control/decode logic and the register file. It is the write/read initiator for that interface.

Parameters:
- DATA_W, 8, register and immediate width.
- ADDR_W, 3, register select width (2**ADDR_W registers).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset. Asserted (0) forces reset state immediately; released synchronously in effect at the next posedge.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 LOADI, 01 MOV, 10 ADD, 11 SUB.
- cmd_dst  in  ADDR_W  destination register.
- cmd_src_a  in  ADDR_W  first source (MOV/ADD/SUB).
- cmd_src_b  in  ADDR_W  second source (ADD/SUB).
- cmd_imm  in  DATA_W  immediate (LOADI).
- rsp_valid  out  1  one-cycle pulse: command completed.
- rsp_data  out  DATA_W  value written to cmd_dst; valid with rsp_valid.
- rsp_zero  out  1  result == 0; valid with rsp_valid.
- rsp_carry  out  1  ADD carry-out / SUB borrow (a<b); 0 for LOADI/MOV.
- rf_read_sel  out  ADDR_W  register file read select.
- rf_data_out  in  DATA_W  register file combinational read data.
- rf_write_sel  out  ADDR_W  register file write select.
- rf_write_en  out  1  register file write enable.
- rf_data_in  out  DATA_W  register file write data.

Behaviour:
- States: IDLE, RD_A, RD_B, WRITE.
- Reset (reset=0, any state): state=IDLE; latched command, operand A and operand B cleared to 0.
  - Outputs during reset: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_carry=0, rf_write_en=0, rf_read_sel=0, rf_write_sel=0, rf_data_in=0.
- IDLE:
  - cmd_ready=1; all other control outputs 0.
  - Accept when cmd_valid=1 at posedge: latch op/dst/src_a/src_b/imm.
  - Next state: LOADI -> WRITE; MOV/ADD/SUB -> RD_A.
  - cmd_valid=0: stay IDLE.
- RD_A:
  - rf_read_sel=src_a; capture rf_data_out into opA at posedge.
  - Next state: MOV -> WRITE; ADD/SUB -> RD_B.
- RD_B: rf_read_sel=src_b; capture rf_data_out into opB at posedge; next state WRITE.
- WRITE:
  - rf_write_en=1, rf_write_sel=dst, rf_data_in=result.
  - rsp_valid=1, rsp_data=result, rsp_zero=(result==0), rsp_carry as defined.
  - Next state: IDLE unconditionally.
- cmd_ready=0 in every state except IDLE. Commands presented while busy are not accepted and must be held by the source.
- Result arithmetic is a DATA_W-bit wrap:
  - LOADI = imm.
  - MOV = opA.
  - ADD = (opA+opB) mod 2**DATA_W; carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB = (opA-opB) mod 2**DATA_W; carry = (opA<opB).
- Latency from the accept edge to the WRITE cycle: LOADI 1 cycle, MOV 2, ADD/SUB 3.
- Command throughput: minimum 2 / 3 / 4 cycles per command respectively, because the IDLE cycle is mandatory.
- rf_read_sel holds its last value in IDLE/WRITE; it may be don't-care functionally but must not be X.
- Source equals destination, including ADD r1,r1,r1: legal. Operands are captured before the write, so old values are used.
- Back-to-back dependent commands: the write lands at the end of WRITE, before the next command's RD_A, so there is no hazard and no forwarding.
- Reset asserted mid-operation: the command is dropped. No rf_write_en and no rsp_valid is produced for it; the register file contents are not touched by this block.
- cmd_* inputs are sampled only at the accept edge. Changes afterwards have no effect.

Decomposition:
- Shared package holds:
  - opcode constants OP_LOADI=2'b00, OP_MOV=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - state encoding S_IDLE, S_RD_A, S_RD_B, S_WRITE;
  - default widths DATA_W=8, ADDR_W=3.
- One natural sub-module: rf_seq_alu. It is combinational: op, opA, opB, imm -> result, zero, carry. It is reusable by later datapath blocks.
- FSM and operand registers stay in rf_sequencer.

Test Plan:
- Reset check: reset=0 mid-ADD in RD_B -> immediately cmd_ready=1, rf_write_en=0, rsp_valid=0. After release, a register file model shows no write.
- LOADI r3,0xA5 accepted at edge N -> at edge N+1 WRITE: rf_write_en=1, rf_write_sel=3, rf_data_in=0xA5, rsp_valid=1, rsp_zero=0, rsp_carry=0. cmd_ready returns to 1 the next cycle.
- LOADI r1,0xF0; LOADI r2,0x20; ADD r4,r1,r2 -> r4=0x10, rsp_carry=1, rsp_zero=0. rf_read_sel=1 then 2 on consecutive cycles.
- LOADI r5,0x07; SUB r6,r5,r5 -> r6=0x00, rsp_zero=1, rsp_carry=0. Then SUB r7,r0(=0),r5 -> r7=0xF9, rsp_carry=1.
- MOV r0,r3 with cmd_valid held high and the next command queued -> cmd_ready=0 for exactly 2 cycles after accept. The next command is accepted only in the IDLE cycle; r0=0xA5.
- Self-dependent ADD r1,r1,r1 (r1=0x81) -> r1=0x02, carry=1. A following ADD r2,r1,r1 reads the new value 0x02 -> r2=0x04.

Source files
------------

// File: rtl/rf_sequencer_pkg.sv
// Shared types and defaults for the register-file sequencer and its ALU.
// Opcode and state encodings live here so later datapath blocks can reuse them.
package rf_sequencer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_LOADI = 2'b00,
    OP_MOV   = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RD_A  = 2'b01,
    S_RD_B  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational result/flag unit: LOADI, MOV, wrapping ADD with carry-out,
// wrapping SUB with borrow (a < b).
module rf_seq_alu
  import rf_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // One extra bit on the sum/difference carries the carry-out or the borrow
  always_comb begin
    sum_s  = {1'b0, op_a} + {1'b0, op_b};
    diff_s = {1'b0, op_a} - {1'b0, op_b};
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_LOADI: result = imm;
      OP_MOV:   result = op_a;
      OP_ADD: begin
        result = sum_s[DATA_W-1:0];
        carry  = sum_s[DATA_W];
      end
      OP_SUB: begin
        result = diff_s[DATA_W-1:0];
        carry  = diff_s[DATA_W];
      end
      default: begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
      end
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/rf_sequencer.sv
// Command-driven master for a single-read/single-write register file: accepts one
// LOADI/MOV/ADD/SUB at a time, sequences the read and write ports, reports result and flags.
module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [ADDR_W-1:0] rf_read_sel,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_write_sel,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_data_in
);

  state_e            state_r;
  op_e               op_r;
  logic [ADDR_W-1:0] dst_r, src_a_r, src_b_r;
  logic [DATA_W-1:0] imm_r, opa_r, opb_r;

  logic              cmd_ready_r, rsp_valid_r, rsp_zero_r, rsp_carry_r, rf_write_en_r;
  logic [DATA_W-1:0] rsp_data_r, rf_data_in_r;
  logic [ADDR_W-1:0] rf_read_sel_r, rf_write_sel_r;

  op_e               alu_op_s;
  logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_imm_s, alu_result_s;
  logic              alu_zero_s, alu_carry_s;
  logic [ADDR_W-1:0] write_dst_s;
  logic              enter_write_s;

  // Present the ALU with the operands being captured at this edge, so WRITE-cycle outputs can be registered
  always_comb begin
    alu_op_s      = op_r;
    alu_a_s       = opa_r;
    alu_b_s       = opb_r;
    alu_imm_s     = imm_r;
    write_dst_s   = dst_r;
    enter_write_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        alu_op_s      = op_e'(cmd_op);
        alu_imm_s     = cmd_imm;
        write_dst_s   = cmd_dst;
        enter_write_s = cmd_valid && (op_e'(cmd_op) == OP_LOADI);
      end
      S_RD_A: begin
        alu_a_s       = rf_data_out;
        enter_write_s = (op_r == OP_MOV);
      end
      S_RD_B: begin
        alu_b_s       = rf_data_out;
        enter_write_s = 1'b1;
      end
      default: enter_write_s = 1'b0;
    endcase
  end

  rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op_s),
    .op_a   (alu_a_s),
    .op_b   (alu_b_s),
    .imm    (alu_imm_s),
    .result (alu_result_s),
    .zero   (alu_zero_s),
    .carry  (alu_carry_s)
  );

  // Sequencer FSM, command/operand latches and registered port outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      op_r           <= OP_LOADI;
      dst_r          <= {ADDR_W{1'b0}};
      src_a_r        <= {ADDR_W{1'b0}};
      src_b_r        <= {ADDR_W{1'b0}};
      imm_r          <= {DATA_W{1'b0}};
      opa_r          <= {DATA_W{1'b0}};
      opb_r          <= {DATA_W{1'b0}};
      cmd_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_data_r     <= {DATA_W{1'b0}};
      rsp_zero_r     <= 1'b0;
      rsp_carry_r    <= 1'b0;
      rf_write_en_r  <= 1'b0;
      rf_write_sel_r <= {ADDR_W{1'b0}};
      rf_data_in_r   <= {DATA_W{1'b0}};
      rf_read_sel_r  <= {ADDR_W{1'b0}};
    end else begin
      // Write-port and response outputs are non-zero only in the WRITE cycle
      rf_write_en_r  <= enter_write_s;
      rsp_valid_r    <= enter_write_s;
      rf_write_sel_r <= enter_write_s ? write_dst_s : {ADDR_W{1'b0}};
      rf_data_in_r   <= enter_write_s ? alu_result_s : {DATA_W{1'b0}};
      rsp_data_r     <= enter_write_s ? alu_result_s : {DATA_W{1'b0}};
      rsp_zero_r     <= enter_write_s ? alu_zero_s : 1'b0;
      rsp_carry_r    <= enter_write_s ? alu_carry_s : 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r        <= op_e'(cmd_op);
            dst_r       <= cmd_dst;
            src_a_r     <= cmd_src_a;
            src_b_r     <= cmd_src_b;
            imm_r       <= cmd_imm;
            cmd_ready_r <= 1'b0;
            if (op_e'(cmd_op) == OP_LOADI) begin
              state_r <= S_WRITE;
            end else begin
              state_r       <= S_RD_A;
              rf_read_sel_r <= cmd_src_a;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        S_RD_A: begin
          opa_r <= rf_data_out;
          if (op_r == OP_MOV) begin
            state_r <= S_WRITE;
          end else begin
            state_r       <= S_RD_B;
            rf_read_sel_r <= src_b_r;
          end
        end
        S_RD_B: begin
          opb_r   <= rf_data_out;
          state_r <= S_WRITE;
        end
        S_WRITE: begin
          state_r     <= S_IDLE;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= S_IDLE;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_zero     = rsp_zero_r;
  assign rsp_carry    = rsp_carry_r;
  assign rf_read_sel  = rf_read_sel_r;
  assign rf_write_sel = rf_write_sel_r;
  assign rf_write_en  = rf_write_en_r;
  assign rf_data_in   = rf_data_in_r;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: a register-file model serves the DUT ports, and a
// reference register array predicts each response when the command is accepted.
module tb_rf_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid, rsp_zero, rsp_carry;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rf_read_sel, rf_write_sel;
  logic [DW-1:0] rf_data_out, rf_data_in;
  logic          rf_write_en;

  always #5 clk = ~clk;

  rf_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rf_read_sel(rf_read_sel), .rf_data_out(rf_data_out),
    .rf_write_sel(rf_write_sel), .rf_write_en(rf_write_en), .rf_data_in(rf_data_in)
  );

  // Register file the DUT drives: combinational read, write at posedge
  logic [DW-1:0] rf_mem [8] = '{default: 8'h00};
  assign rf_data_out = rf_mem[rf_read_sel];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_sel] <= rf_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int dst;
    int data;
    int zero;
    int carry;
    int cyc;
  } exp_t;
  exp_t q[$];

  int model[8] = '{default: 0};
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop the oldest prediction whenever a response appears
  always @(negedge clk) begin
    exp_t e;
    if (reset && (rsp_valid || rf_write_en)) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_data", int'(rsp_data), e.data);
        chk("rsp_zero", int'(rsp_zero), e.zero);
        chk("rsp_carry", int'(rsp_carry), e.carry);
        chk("rf_write_en", int'(rf_write_en), 1);
        chk("rf_write_sel", int'(rf_write_sel), e.dst);
        chk("rf_data_in", int'(rf_data_in), e.data);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Present a command, wait for acceptance, optionally predict its response
  task automatic issue(input logic [1:0] op, input int dst, input int a, input int b,
                       input int imm, input bit hold, input bit track);
    int n;
    int r;
    int c;
    int lat;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = AW'(dst);
    cmd_src_a = AW'(a);
    cmd_src_b = AW'(b);
    cmd_imm   = DW'(imm);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      c = 0;
      case (op)
        2'd0: begin r = imm; lat = 1; end
        2'd1: begin r = model[a]; lat = 2; end
        2'd2: begin
          r = model[a] + model[b];
          c = (r > 255) ? 1 : 0;
          r = r % 256;
          lat = 3;
        end
        default: begin
          c = (model[a] < model[b]) ? 1 : 0;
          r = (model[a] - model[b] + 256) % 256;
          lat = 3;
        end
      endcase
      model[dst] = r;
      e.dst = dst; e.data = r; e.zero = (r == 0) ? 1 : 0; e.carry = c; e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_dst   = AW'($urandom);
      cmd_src_a = AW'($urandom);
      cmd_src_b = AW'($urandom);
      cmd_imm   = DW'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rf_write_en", int'(rf_write_en), 0);
    chk("reset_rf_read_sel", int'(rf_read_sel), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // LOADI r3,0xA5 then ready returns the following cycle
    issue(2'd0, 3, 0, 0, 8'hA5, 1'b0, 1'b1);
    chk("loadi_busy_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("loadi_ready_back", int'(cmd_ready), 1);

    issue(2'd0, 1, 0, 0, 8'hF0, 1'b0, 1'b1);
    issue(2'd0, 2, 0, 0, 8'h20, 1'b0, 1'b1);
    issue(2'd2, 4, 1, 2, 0, 1'b0, 1'b1);
    chk("add_rd_sel_a", int'(rf_read_sel), 1);
    @(posedge clk); #1;
    chk("add_rd_sel_b", int'(rf_read_sel), 2);

    issue(2'd0, 5, 0, 0, 8'h07, 1'b0, 1'b1);
    issue(2'd3, 6, 5, 5, 0, 1'b0, 1'b1);
    issue(2'd3, 7, 0, 5, 0, 1'b0, 1'b1);

    // MOV r0,r3 with the next command held on the bus
    issue(2'd1, 0, 3, 0, 0, 1'b1, 1'b1);
    cmd_op = 2'd0; cmd_dst = 3'd1; cmd_imm = 8'h81;
    busy = 0;
    while (!cmd_ready && busy < 10) begin
      busy++;
      @(posedge clk); #1;
    end
    chk("mov_busy_cycles", busy, 2);
    issue(2'd0, 1, 0, 0, 8'h81, 1'b0, 1'b1);

    issue(2'd2, 1, 1, 1, 0, 1'b0, 1'b1);
    issue(2'd2, 2, 1, 1, 0, 1'b0, 1'b1);

    // Reset while an ADD sits in RD_B: command must vanish
    issue(2'd2, 4, 1, 2, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midop_cmd_ready", int'(cmd_ready), 1);
    chk("midop_rf_write_en", int'(rf_write_en), 0);
    chk("midop_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("after_reset_r%0d", i), int'(rf_mem[i]), model[i]);

    // Random command stream with random gaps
    for (int k = 0; k < 200; k++) begin
      issue(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), int'(rf_mem[i]), model[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
